mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single 32-bit memory port (SRAM plus the 0xFF00xxxx hardware-register window) between the vector processor core and a secondary master such as a UART boot loader or DMA engine. It grants requests round-robin, tracks up to `MAX_OUTST` in-flight transactions in an in-order ID queue, and routes each `rvalid`/`err`/`rdata` response back to the requester that issued it. It sits between the masters and the memory/hwreg address decode.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if;
   logic [1:0]        req_i;
   logic [1:0]        we_i;
   logic [1:0][3:0]   be_i;
   logic [1:0][31:0]  addr_i;
   logic [1:0][31:0]  wdata_i;
   logic [1:0]        gnt_o;
   logic [1:0]        rvalid_o;
   logic [1:0]        err_o;
   logic [31:0]       rdata_o;
   logic              mem_req_o;
   logic              mem_gnt_i;
   logic              mem_we_o;
   logic [3:0]        mem_be_o;
   logic [31:0]       mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_rvalid_i;
   logic              mem_err_i;
   logic [31:0]       mem_rdata_i;
   logic              spurious_o;

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, err_o, rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
      output spurious_o
   );

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, err_o, rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
      input  spurious_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin memory arbiter with in-order response routing.
// Optional MEM_ARB_STATS_EN adds saturating per-requester grant counters on stats_o.
module mem_arbiter #(
   parameter int MAX_OUTST = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   mem_arbiter_if.slave     bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [1:0][31:0] stats_o
`endif
);

   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CW = PW + 1;

   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;
   logic [CW-1:0]        count;
   logic [MAX_OUTST-1:0] id_q;
   logic                 prio;
   logic                 spurious;

   logic       sel;
   logic       can_issue;
   logic       mem_req;
   logic       grant;
   logic [1:0] gnt;
   logic       q_nonempty;
   logic       head;
   logic       pop;

   always_comb begin
      if (bus.req_i == 2'b11) begin
         sel = prio;
      end else begin
         sel = bus.req_i[1];
      end
      can_issue  = (count < CW'(MAX_OUTST));
      // Reset gating keeps the request/grant quiet while rst_i is held.
      mem_req    = (|bus.req_i) & can_issue & ~rst_i;
      grant      = mem_req & bus.mem_gnt_i;
      gnt        = 2'b00;
      gnt[sel]   = grant;
      q_nonempty = (count != '0);
      head       = id_q[rd_ptr];
      pop        = bus.mem_rvalid_i & q_nonempty;
   end

   always_comb begin
      bus.gnt_o            = gnt;
      bus.mem_req_o        = mem_req;
      bus.mem_we_o         = bus.we_i[sel];
      bus.mem_be_o         = bus.be_i[sel];
      bus.mem_addr_o       = bus.addr_i[sel];
      bus.mem_wdata_o      = bus.wdata_i[sel];
      bus.rvalid_o         = 2'b00;
      bus.rvalid_o[head]   = pop;
      bus.err_o            = 2'b00;
      bus.err_o[head]      = bus.mem_err_i & q_nonempty;
      bus.rdata_o          = bus.mem_rdata_i;
      bus.spurious_o       = spurious;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         id_q     <= '0;
         prio     <= 1'b0;
         spurious <= 1'b0;
      end else begin
         if (grant) begin
            id_q[wr_ptr] <= sel;
            wr_ptr       <= wr_ptr + 1'b1;
            prio         <= ~sel;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({grant, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (bus.mem_rvalid_i && !q_nonempty) begin
            spurious <= 1'b1;
         end
      end
   end

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stats_o <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (gnt[k] && (stats_o[k] != 32'hFFFF_FFFF)) begin
               stats_o[k] <= stats_o[k] + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (MAX_OUTST=4).
// Define MEM_ARB_STATS_EN to also exercise the grant counters.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus();
`ifdef MEM_ARB_STATS_EN
   logic [1:0][31:0] stats;
`endif

   mem_arbiter #(.MAX_OUTST(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
`ifdef MEM_ARB_STATS_EN
      ,
      .stats_o (stats)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_i        = 2'b00;
      bus.we_i         = 2'b00;
      bus.be_i         = '0;
      bus.addr_i       = '0;
      bus.wdata_i      = '0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_err_i    = 1'b0;
      bus.mem_rdata_i  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #1;
      check("rst_gnt", 32'(bus.gnt_o), 32'h0);
      check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("rst_err", 32'(bus.err_o), 32'h0);
      check("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
      check("rst_spurious", 32'(bus.spurious_o), 32'h0);
      bus.req_i     = 2'b11;
      bus.mem_gnt_i = 1'b1;
      #1;
      check("rst_gnt_held", 32'(bus.gnt_o), 32'h0);
      check("rst_mem_req_held", 32'(bus.mem_req_o), 32'h0);
      cyc();
      idle();
      rst = 1'b0;
      cyc();

      // Single requester, back-to-back reads
      bus.req_i     = 2'b01;
      bus.mem_gnt_i = 1'b1;
      bus.addr_i[0] = 32'h100;
      bus.be_i[0]   = 4'hF;
      #1;
      check("single_gnt0", 32'(bus.gnt_o), 32'h1);
      check("single_addr0", bus.mem_addr_o, 32'h100);
      cyc();
      for (int i = 0; i < 3; i++) begin
         bus.req_i        = (i < 2) ? 2'b01 : 2'b00;
         bus.addr_i[0]    = 32'h104 + 32'(4 * i);
         bus.mem_rvalid_i = 1'b1;
         bus.mem_rdata_i  = 32'hA0 + 32'(i);
         #1;
         check("single_gnt", 32'(bus.gnt_o), (i < 2) ? 32'h1 : 32'h0);
         check("single_rvalid", 32'(bus.rvalid_o), 32'h1);
         check("single_rdata", bus.rdata_o, 32'hA0 + 32'(i));
         cyc();
      end
      idle();

      // Contention after reset: alternate grants, responses follow issue order
      do_reset();
      bus.req_i     = 2'b11;
      bus.mem_gnt_i = 1'b1;
      bus.addr_i[0] = 32'h200;
      bus.addr_i[1] = 32'h300;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_gnt", 32'(bus.gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
         check("cont_addr", bus.mem_addr_o, (i % 2 == 0) ? 32'h200 : 32'h300);
         cyc();
      end
      bus.req_i = 2'b00;
      for (int i = 0; i < 4; i++) begin
         bus.mem_rvalid_i = 1'b1;
         #1;
         check("cont_rvalid", 32'(bus.rvalid_o), (i % 2 == 0) ? 32'h1 : 32'h2);
         cyc();
      end
      idle();

      // Full queue, then push+pop in the same cycle
      bus.req_i     = 2'b01;
      bus.mem_gnt_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("full_gnt", 32'(bus.gnt_o), 32'h1);
         cyc();
      end
      #1;
      check("full_mem_req", 32'(bus.mem_req_o), 32'h0);
      check("full_gnt_blocked", 32'(bus.gnt_o), 32'h0);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hB0;
      #1;
      check("full_pop_rvalid", 32'(bus.rvalid_o), 32'h1);
      check("full_pop_no_gnt", 32'(bus.gnt_o), 32'h0);
      cyc();
      bus.mem_rdata_i = 32'hB1;
      #1;
      check("pushpop_gnt", 32'(bus.gnt_o), 32'h1);
      check("pushpop_rvalid", 32'(bus.rvalid_o), 32'h1);
      cyc();
      bus.mem_rvalid_i = 1'b0;
      #1;
      check("after_pushpop_gnt", 32'(bus.gnt_o), 32'h1);
      cyc();
      #1;
      check("refull_gnt", 32'(bus.gnt_o), 32'h0);
      bus.req_i = 2'b00;
      for (int i = 0; i < 4; i++) begin
         bus.mem_rvalid_i = 1'b1;
         #1;
         check("full_drain", 32'(bus.rvalid_o), 32'h1);
         cyc();
      end
      idle();

      // Back-pressure then error response
      bus.req_i      = 2'b10;
      bus.we_i       = 2'b10;
      bus.be_i[1]    = 4'hC;
      bus.addr_i[1]  = 32'hFF00_0010;
      bus.wdata_i[1] = 32'h5555_AAAA;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_gnt", 32'(bus.gnt_o), 32'h0);
         check("bp_mem_req", 32'(bus.mem_req_o), 32'h1);
         check("bp_addr", bus.mem_addr_o, 32'hFF00_0010);
         check("bp_wdata", bus.mem_wdata_o, 32'h5555_AAAA);
         cyc();
      end
      bus.mem_gnt_i = 1'b1;
      #1;
      check("bp_gnt_release", 32'(bus.gnt_o), 32'h2);
      check("bp_we", 32'(bus.mem_we_o), 32'h1);
      check("bp_be", 32'(bus.mem_be_o), 32'hC);
      cyc();
      bus.req_i        = 2'b00;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_err_i    = 1'b1;
      #1;
      check("err_rvalid", 32'(bus.rvalid_o), 32'h2);
      check("err_err", 32'(bus.err_o), 32'h2);
      cyc();
      idle();

      // Spurious response, then reset with two outstanding
      bus.mem_rvalid_i = 1'b1;
      #1;
      check("spur_rvalid", 32'(bus.rvalid_o), 32'h0);
      cyc();
      bus.mem_rvalid_i = 1'b0;
      #1;
      check("spur_flag", 32'(bus.spurious_o), 32'h1);
      bus.req_i     = 2'b01;
      bus.mem_gnt_i = 1'b1;
      cyc();
      cyc();
      #2;
      rst = 1'b1;
      bus.mem_rvalid_i = 1'b1;
      #1;
      check("arst_gnt", 32'(bus.gnt_o), 32'h0);
      check("arst_mem_req", 32'(bus.mem_req_o), 32'h0);
      check("arst_spurious", 32'(bus.spurious_o), 32'h0);
      check("arst_rvalid", 32'(bus.rvalid_o), 32'h0);
      cyc();
      rst = 1'b0;
      bus.req_i = 2'b00;
      #1;
      check("arst_count_zero", 32'(bus.rvalid_o), 32'h0);
      cyc();
      bus.mem_rvalid_i = 1'b0;
      #1;
      check("arst_spur_again", 32'(bus.spurious_o), 32'h1);

`ifdef MEM_ARB_STATS_EN
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.req_i        = 2'b10;
         bus.mem_gnt_i    = 1'b1;
         bus.mem_rvalid_i = 1'b0;
         #1;
         check("stats_gnt", 32'(bus.gnt_o), 32'h2);
         cyc();
         bus.req_i        = 2'b00;
         bus.mem_rvalid_i = 1'b1;
         #1;
         check("stats_rvalid", 32'(bus.rvalid_o), 32'h2);
         cyc();
      end
      idle();
      #1;
      check("stats1", stats[1], 32'd5);
      check("stats0", stats[0], 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
